// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one registered DATA_W x DATA_W unsigned multiplier among NUM_REQ requesters.
// Optional completed-operation counter enabled by defining MULT_RR_ARBITER_STATS_EN.
//
// state | meaning
// IDLE  | scan for a valid requester from rr_ptr, grant combinationally, capture operands
// CALC  | register the full-width product of the captured operands
// RESP  | present resp_valid/resp_product to the granted requester until it accepts
module mult_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]   req_a,
   input  logic [NUM_REQ*DATA_W-1:0]   req_b,
   output logic [NUM_REQ-1:0]          resp_valid,
   input  logic [NUM_REQ-1:0]          resp_ready,
   output logic [2*DATA_W-1:0]         resp_product,
   output logic                        busy,
   output logic [15:0]                 op_count
);

   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state;
   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W-1:0]    grant_reg;
   logic [DATA_W-1:0]   a_reg;
   logic [DATA_W-1:0]   b_reg;

   logic                grant_found;
   logic [PTR_W-1:0]    grant_idx;
   logic                resp_hs;

   // Priority scan starting at rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!grant_found && req_valid[idx[PTR_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = idx[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!rst && state == IDLE && grant_found)
         req_ready = NUM_REQ'(1) << grant_idx;
   end

   assign busy    = (state != IDLE);
   assign resp_hs = (state == RESP) && resp_ready[grant_reg];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         grant_reg    <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         resp_valid   <= '0;
         resp_product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  a_reg     <= req_a[grant_idx*DATA_W +: DATA_W];
                  b_reg     <= req_b[grant_idx*DATA_W +: DATA_W];
                  grant_reg <= grant_idx;
                  state     <= CALC;
               end
            end
            CALC: begin
               resp_product <= PROD_W'(a_reg) * PROD_W'(b_reg);
               resp_valid   <= NUM_REQ'(1) << grant_reg;
               state        <= RESP;
            end
            RESP: begin
               if (resp_hs) begin
                  resp_valid <= '0;
                  rr_ptr     <= (grant_reg == PTR_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MULT_RR_ARBITER_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         op_count <= '0;
      else if (resp_hs)
         op_count <= op_count + 16'd1;
   end
`else
   assign op_count = '0;
`endif

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed self-checking bench for mult_rr_arbiter (NUM_REQ=4, DATA_W=16).
module tb_mult_rr_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [3:0]  resp_valid;
   logic [3:0]  resp_ready;
   logic [31:0] resp_product;
   logic        busy;
   logic [15:0] op_count;

   int errors = 0;
   int checks = 0;
   int exp_ops = 0;

   mult_rr_arbiter #(.NUM_REQ(4), .DATA_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_product (resp_product),
      .busy         (busy),
      .op_count     (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [15:0] exp_count();
`ifdef MULT_RR_ARBITER_STATS_EN
      return 16'(exp_ops);
`else
      return 16'd0;
`endif
   endfunction

   // Drives one operation for requester idx; caller sits just after a rising edge.
   task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] prod, output int lat, output bit to);
      bit acc;
      int n;
      acc = 0; n = 0; to = 0; lat = 0; prod = '0;
      req_valid[idx] = 1'b1;
      req_a[idx*16 +: 16] = a;
      req_b[idx*16 +: 16] = b;
      while (!acc && n < 20) begin
         #2 acc = req_ready[idx];
         @(posedge clk); #1;
         n++;
      end
      req_valid[idx] = 1'b0;
      if (!acc) begin to = 1; return; end
      lat = 1;
      while (!resp_valid[idx] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!resp_valid[idx]) begin to = 1; return; end
      prod = resp_product;
      @(posedge clk); #1;
      exp_ops++;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      exp_ops = 0;
   endtask

   task automatic test_reset();
      req_valid = '0; resp_ready = '1; req_a = '0; req_b = '0;
      rst = 1'b1;
      #3;
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
      checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0000", resp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (resp_product !== 32'h0) begin errors++; $display("FAIL reset_product got=%h exp=00000000", resp_product); end
      checks++; if (op_count !== 16'h0) begin errors++; $display("FAIL reset_op_count got=%h exp=0000", op_count); end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      exp_ops = 0;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
   endtask

   task automatic test_single();
      req_valid[1] = 1'b1;
      req_a[16 +: 16] = 16'h0003;
      req_b[16 +: 16] = 16'h0005;
      #3;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_req_ready got=%b exp=0010", req_ready); end
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_calc_busy got=%b exp=1", busy); end
      checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL single_calc_resp_valid got=%b exp=0000", resp_valid); end
      @(posedge clk); #1;
      checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL single_resp_valid got=%b exp=0010", resp_valid); end
      checks++; if (resp_product !== 32'h0000000F) begin errors++; $display("FAIL single_product got=%h exp=0000000f", resp_product); end
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL single_resp_req_ready got=%b exp=0000", req_ready); end
      @(posedge clk); #1;
      exp_ops++;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
      checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL single_idle_resp_valid got=%b exp=0000", resp_valid); end
      checks++; if (op_count !== exp_count()) begin errors++; $display("FAIL single_op_count got=%h exp=%h", op_count, exp_count()); end
   endtask

   task automatic test_max_values();
      logic [31:0] p; int lat; bit to;
      do_op(0, 16'hFFFF, 16'hFFFF, p, lat, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL max_timeout got=%b exp=0", to); end
      checks++; if (p !== 32'hFFFE0001) begin errors++; $display("FAIL max_product got=%h exp=fffe0001", p); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL max_latency got=%0d exp=2", lat); end
      do_op(1, 16'h0000, 16'h1234, p, lat, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL zero_timeout got=%b exp=0", to); end
      checks++; if (p !== 32'h00000000) begin errors++; $display("FAIL zero_product got=%h exp=00000000", p); end
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_prod [4];
      int n;
      int g;
      exp_prod[0] = 32'h00000200;
      exp_prod[1] = 32'h00000303;
      exp_prod[2] = 32'h00000408;
      exp_prod[3] = 32'h0000050F;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         req_a[i*16 +: 16] = 16'(i + 2);
         req_b[i*16 +: 16] = 16'(16'h0100 + i);
      end
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         g = k % 4;
         #2;
         checks++; if (req_ready !== (4'b0001 << g)) begin errors++; $display("FAIL rr_grant_%0d got=%b exp=%b", k, req_ready, 4'b0001 << g); end
         @(posedge clk); #1;
         n = 0;
         while (resp_valid === 4'b0 && n < 10) begin @(posedge clk); #1; n++; end
         checks++; if (resp_valid !== (4'b0001 << g)) begin errors++; $display("FAIL rr_resp_valid_%0d got=%b exp=%b", k, resp_valid, 4'b0001 << g); end
         checks++; if (resp_product !== exp_prod[g]) begin errors++; $display("FAIL rr_product_%0d got=%h exp=%h", k, resp_product, exp_prod[g]); end
         @(posedge clk); #1;
         exp_ops++;
      end
      req_valid = '0;
      // last op was requester 0; drain whatever got granted in this idle cycle
      @(posedge clk); #1;
      n = 0;
      while (busy === 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
      if (n > 0) exp_ops++;
   endtask

   task automatic test_backpressure();
      apply_reset();
      resp_ready = 4'b1011;
      req_valid[2] = 1'b1;
      req_a[32 +: 16] = 16'h0010;
      req_b[32 +: 16] = 16'h0011;
      #2;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant got=%b exp=0100", req_ready); end
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      req_valid[0] = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL bp_resp_valid_%0d got=%b exp=0100", c, resp_valid); end
         checks++; if (resp_product !== 32'h00000110) begin errors++; $display("FAIL bp_product_%0d got=%h exp=00000110", c, resp_product); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_%0d got=%b exp=1", c, busy); end
         checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_req_ready_%0d got=%b exp=0000", c, req_ready); end
         @(posedge clk); #1;
      end
      req_valid = '0;
      resp_ready = 4'b1111;
      @(posedge clk); #1;
      exp_ops++;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy got=%b exp=0", busy); end
      checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL bp_release_resp_valid got=%b exp=0000", resp_valid); end
      checks++; if (op_count !== exp_count()) begin errors++; $display("FAIL bp_op_count got=%h exp=%h", op_count, exp_count()); end
   endtask

   task automatic test_reset_calc();
      req_valid[3] = 1'b1;
      req_a[48 +: 16] = 16'h0007;
      req_b[48 +: 16] = 16'h0009;
      #2;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rc_grant got=%b exp=1000", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      rst = 1'b1;
      #1;
      checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL rc_resp_valid got=%b exp=0000", resp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rc_busy got=%b exp=0", busy); end
      checks++; if (op_count !== 16'h0) begin errors++; $display("FAIL rc_op_count got=%h exp=0000", op_count); end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      exp_ops = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL rc_no_resp_%0d got=%b exp=0000", c, resp_valid); end
      end
      req_valid = 4'b0101;
      #2;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rc_priority got=%b exp=0001", req_ready); end
      req_valid = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_op_count();
      logic [31:0] p; int lat; bit to;
      apply_reset();
      do_op(2, 16'h0002, 16'h0003, p, lat, to);
      checks++; if (p !== 32'h00000006) begin errors++; $display("FAIL cnt_prod_a got=%h exp=00000006", p); end
      do_op(3, 16'h1000, 16'h0010, p, lat, to);
      checks++; if (p !== 32'h00010000) begin errors++; $display("FAIL cnt_prod_b got=%h exp=00010000", p); end
      do_op(0, 16'h8000, 16'h0002, p, lat, to);
      checks++; if (p !== 32'h00010000) begin errors++; $display("FAIL cnt_prod_c got=%h exp=00010000", p); end
`ifdef MULT_RR_ARBITER_STATS_EN
      checks++; if (op_count !== 16'd3) begin errors++; $display("FAIL cnt_three got=%h exp=0003", op_count); end
`else
      checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL cnt_disabled got=%h exp=0000", op_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_max_values();
      test_round_robin();
      test_backpressure();
      test_reset_calc();
      test_op_count();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mult_rr_arbiter.md
Name: mult_rr_arbiter

Overview:
- Shares one registered 16x16 unsigned multiplier between NUM_REQ requesters using a round-robin policy.
- Each requester presents operands through a valid/ready handshake and receives a 32-bit product through a valid/ready response.
- Only one operation is in flight at a time.
- Sits between the datapath clients and the single multiplier instance in the arithmetic subsystem.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand width; product width is 2*DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester operand accept; one-hot or zero.
- req_a  in  NUM_REQ*DATA_W  packed operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  packed operand B, same packing as req_a.
- resp_valid  out  NUM_REQ  per-requester result valid; one-hot or zero.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_product  out  2*DATA_W  product for the requester whose resp_valid is high.
- busy  out  1  high whenever state is not IDLE.
- op_count  out  16  completed-operation counter (optional feature).

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_product=0, busy=0, op_count=0, operand registers=0.
- States are IDLE, CALC and RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On the handshake (valid & ready), capture req_a[g], req_b[g] and g, then go to CALC.
  - With no req_valid bits high, stay in IDLE with req_ready=0.
- CALC: register product = a*b (unsigned, full 2*DATA_W width, no truncation), then go to RESP. No handshakes occur in this state.
- RESP:
  - resp_valid[g]=1 and resp_product holds its value stable until resp_ready[g]=1.
  - On resp_ready[g], go to IDLE, clear resp_valid, set rr_ptr=(g+1) mod NUM_REQ.
  - resp_ready bits other than g are ignored.
- Latency: request accepted in cycle T, resp_valid high from cycle T+2.
- Throughput: at most one operation per 3 cycles when resp_ready is held high.
- req_ready is 0 in CALC and RESP; the requester must hold req_valid and operands until accepted.
- A requester deasserting req_valid before grant is legal; it simply is not selected.
- req_valid from the requester currently in RESP is ignored until the state returns to IDLE.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Fairness: a requester that holds req_valid continuously is granted within NUM_REQ operations.
- Reset mid-operation: the in-flight operation is discarded silently, no response is issued, and all reset values apply immediately.
- resp_product keeps its last value after the handshake; it is only meaningful while some resp_valid bit is high.

Optional Feature:
- Macro MULT_RR_ARBITER_STATS_EN.
- When defined: op_count increments by 1 on each response handshake, wraps from 0xFFFF to 0x0000, and resets to 0.
- When undefined: op_count is tied to 0 and no counter logic is synthesized.

Test Plan:
- Single requester: req 1 sends a=0x0003, b=0x0005 with resp_ready=1 -> resp_valid[1] high two cycles after acceptance, resp_product=0x0000000F, back in IDLE next cycle.
- Maximum values: a=0xFFFF, b=0xFFFF -> resp_product=0xFFFE0001; a=0x0000, b=0x1234 -> 0x00000000.
- Round-robin: all 4 requesters hold req_valid after reset -> grant order 0,1,2,3,0; each response carries that requester's own product.
- Backpressure: resp_ready[g]=0 for 5 cycles -> resp_valid and resp_product stay stable, busy=1, req_ready stays 0; release -> state returns to IDLE.
- Reset during CALC: assert rst -> resp_valid=0, busy=0, no response issued; after release, requester 0 has priority.
- With MULT_RR_ARBITER_STATS_EN: 3 completed operations -> op_count=3. Without the macro -> op_count=0 throughout.
